grf_wb_arbiter: RTL
===================

# grf_wb_arbiter

Write-back arbiter that sits in front of the GRF write port. It merges register writes from two producers into the GRF's single write port: the main pipeline write-back (port A, never stalled) and a multi-cycle unit such as mul/div (port B, valid/ready handshake). Port B writes are buffered in a small FIFO. The block also reports pending writes so the hazard unit can stall readers of registers that still have a queued write.

## Interface
- DEPTH, 4, port-B FIFO depth in entries; must be a power of 2, ≥2.
- CW, $clog2(DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- a_we  in  1  pipeline write request this cycle.
- a_wa  in  5  pipeline destination register.
- a_wd  in  32  pipeline write data.
- a_pc  in  32  PC of the pipeline instruction.
- b_valid  in  1  port-B request valid.
- b_ready  out  1  port-B FIFO can accept.
- b_wa  in  5  port-B destination register.
- b_wd  in  32  port-B write data.
- b_pc  in  32  PC of the port-B instruction.
- regWE  out  1  GRF write enable (registered).
- regWA  out  5  GRF write address (registered).
- regWD  out  32  GRF write data (registered).
- PC  out  32  PC forwarded to GRF for write logging (registered).
- chk_a1  in  5  register address queried by the hazard unit.
- chk_a2  in  5  second queried address.
- pend1  out  1  chk_a1 has a write held in the block.
- pend2  out  1  chk_a2 has a write held in the block.
- fifo_count  out  CW  current FIFO occupancy, 0..DEPTH.

## Operation
- Issue selection on each posedge, priority fixed:
  - If a_we=1, the output register loads {1, a_wa, a_wd, a_pc}.
  - Else if the FIFO is non-empty, the head is popped and loaded.
  - Else regWE is loaded with 0. regWA/regWD/PC then also load 0.
- Port A is never back-pressured. If A requests every cycle, port B starves. Bounding that is the pipeline's responsibility.
- b_ready = (fifo_count < DEPTH) && !reset. It depends only on stored count, not on a same-cycle pop.
- A push occurs on a posedge with b_valid && b_ready. A pushed entry cannot be popped on the same edge; it becomes eligible one edge later.
- Simultaneous push and pop: count is unchanged, the head advances and the tail is written.
- FIFO order is strictly preserved. A and B entries are never reordered against each other beyond the priority rule. Address conflicts between A and B are prevented upstream using pend1/pend2.
- Writes to $0 pass through unchanged (regWE=1, regWA=0); the GRF discards them.
- Pending detection, from stored state only:
  - pendN=1 iff chk_aN≠0 and (any valid FIFO entry has wa==chk_aN, or regWE=1 with regWA==chk_aN).
  - Inputs on the current cycle's A/B ports are not included.
- Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_count distinguishes full from empty.

## Timing
- Reset values while reset is asserted: regWE=0, regWA=0, regWD=0, PC=0, fifo_count=0, b_ready=0, pend1=pend2=0.
  - FIFO contents are invalidated.
  - Entries in flight are dropped, with no partial write.
- Port A latency: request sampled at edge t, outputs valid during cycle t+1, GRF write at edge t+1.
- Port B minimum latency, FIFO empty and A idle: push at edge t, pop/issue at edge t+1, GRF write at edge t+2.
- Throughput is one GRF write per cycle in total.
- b_ready first rises in the cycle after reset deasserts and stays high until DEPTH entries are queued.
- pendN falls in the cycle after the matching entry's GRF write edge.

## Test plan
- Reset, then idle 3 cycles -> all outputs 0, b_ready=1, fifo_count=0.
- a_we=1, a_wa=5, a_wd=0x12345678, a_pc=0x00003000 for one cycle -> next cycle regWE=1, regWA=5, regWD=0x12345678, PC=0x00003000; the cycle after, regWE=0.
- A idle; push B wa=8, wd=0xDEADBEEF; hold chk_a1=8:
  - After the push edge: fifo_count=1, pend1=1.
  - One cycle later: regWA=8, fifo_count=0, pend1 still 1.
  - One cycle after that: pend1=0.
- DEPTH=4; A active 6 consecutive cycles while B offers wa=1..5 back-to-back:
  - b_ready drops after 4 pushes, and wa=5 is held with b_valid.
  - After A stops, regWA issues 1,2,3,4,5 on consecutive cycles, with wa=5 pushed as soon as space frees.
- B push wa=0, wd=0xFFFFFFFF with chk_a1=0 -> issued with regWE=1, regWA=0; pend1 stays 0 throughout.
- 3 B entries queued, then reset asserted mid-cycle between edges -> outputs go to 0 immediately and fifo_count=0. After release, no queued entry is ever issued.

Source files
------------

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle between the write-back producers, the hazard unit and the GRF write arbiter.
interface grf_wb_arbiter_if #(
  parameter int unsigned CW = 3
);
  logic          a_we;
  logic [4:0]    a_wa;
  logic [31:0]   a_wd;
  logic [31:0]   a_pc;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_wa;
  logic [31:0]   b_wd;
  logic [31:0]   b_pc;
  logic          regWE;
  logic [4:0]    regWA;
  logic [31:0]   regWD;
  logic [31:0]   PC;
  logic [4:0]    chk_a1;
  logic [4:0]    chk_a2;
  logic          pend1;
  logic          pend2;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  a_we, a_wa, a_wd, a_pc,
    input  b_valid, b_wa, b_wd, b_pc,
    input  chk_a1, chk_a2,
    output b_ready, regWE, regWA, regWD, PC, pend1, pend2, fifo_count
  );

  modport master (
    output a_we, a_wa, a_wd, a_pc,
    output b_valid, b_wa, b_wd, b_pc,
    output chk_a1, chk_a2,
    input  b_ready, regWE, regWA, regWD, PC, pend1, pend2, fifo_count
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Merges pipeline (port A, priority) and buffered multi-cycle (port B) writes onto the single
// GRF write port, and flags registers that still have a write held inside the block.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  grf_wb_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          reg_we_q, reg_we_d;
  logic [4:0]    reg_wa_q, reg_wa_d;
  logic [31:0]   reg_wd_q, reg_wd_d;
  logic [31:0]   pc_q, pc_d;

  logic [4:0]    fifo_wa_q [DEPTH];
  logic [31:0]   fifo_wd_q [DEPTH];
  logic [31:0]   fifo_pc_q [DEPTH];

  logic          push, pop;
  logic [AW-1:0] off;
  logic          slot_vld;
  logic          hit1, hit2;

  assign bus.b_ready = (count_q < CW'(DEPTH)) && !reset;

  // Issue selection: port A wins, otherwise the FIFO head drains; idle cycles load zeros.
  always_comb begin
    push     = bus.b_valid && bus.b_ready;
    pop      = !bus.a_we && (count_q != '0);
    head_d   = head_q;
    tail_d   = tail_q;
    reg_we_d = 1'b0;
    reg_wa_d = 5'd0;
    reg_wd_d = 32'd0;
    pc_d     = 32'd0;
    if (pop)  head_d = head_q + AW'(1);
    if (push) tail_d = tail_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (bus.a_we) begin
      reg_we_d = 1'b1;
      reg_wa_d = bus.a_wa;
      reg_wd_d = bus.a_wd;
      pc_d     = bus.a_pc;
    end else if (pop) begin
      reg_we_d = 1'b1;
      reg_wa_d = fifo_wa_q[head_q];
      reg_wd_d = fifo_wd_q[head_q];
      pc_d     = fifo_pc_q[head_q];
    end
  end

  // Pending lookup over occupied FIFO slots plus the write currently on the GRF port.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    off      = '0;
    slot_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = AW'(i) - head_q;
      slot_vld = {1'b0, off} < count_q;
      if (slot_vld && (fifo_wa_q[i] == bus.chk_a1)) hit1 = 1'b1;
      if (slot_vld && (fifo_wa_q[i] == bus.chk_a2)) hit2 = 1'b1;
    end
    if (reg_we_q && (reg_wa_q == bus.chk_a1)) hit1 = 1'b1;
    if (reg_we_q && (reg_wa_q == bus.chk_a2)) hit2 = 1'b1;
  end

  assign bus.pend1      = hit1 && (bus.chk_a1 != 5'd0);
  assign bus.pend2      = hit2 && (bus.chk_a2 != 5'd0);
  assign bus.regWE      = reg_we_q;
  assign bus.regWA      = reg_wa_q;
  assign bus.regWD      = reg_wd_q;
  assign bus.PC         = pc_q;
  assign bus.fifo_count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      reg_we_q <= 1'b0;
      reg_wa_q <= 5'd0;
      reg_wd_q <= 32'd0;
      pc_q     <= 32'd0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      reg_we_q <= reg_we_d;
      reg_wa_q <= reg_wa_d;
      reg_wd_q <= reg_wd_d;
      pc_q     <= pc_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa_q[tail_q] <= bus.b_wa;
      fifo_wd_q[tail_q] <= bus.b_wd;
      fifo_pc_q[tail_q] <= bus.b_pc;
    end
  end
endmodule
